// File: rtl/sdram_rw_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// sdram_rw_arbiter_pkg
// Shared definitions for the SDRAM read/write burst arbiter:
//   - arbiter FSM state enum
//   - default address / length widths
//   - bank index constants and port indices used by the per-port address
//     generators
//   - last-grant encoding
// ---------------------------------------------------------------------------
package sdram_rw_arbiter_pkg;

    localparam int DEF_ADDR_W = 24;
    localparam int DEF_LEN_W  = 10;

    // Bank indices used by the double-buffering scheme.
    localparam logic BANK_0 = 1'b0;
    localparam logic BANK_1 = 1'b1;

    // Port indices into the per-port signal arrays in the top level.
    localparam int PORT_WR = 0;
    localparam int PORT_RD = 1;

    // Encoding of the last-served port.
    localparam logic GRANT_RD = 1'b0;
    localparam logic GRANT_WR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_BUSY = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_BUSY = 3'd4
    } arb_state_t;

    function automatic logic is_req_state(input arb_state_t s);
        return (s == ST_WR_REQ) || (s == ST_RD_REQ);
    endfunction

endpackage

// File: rtl/sdram_rw_arbiter_addr_gen.sv
// ---------------------------------------------------------------------------
// sdram_addr_gen
// Per-port burst address generator: keeps the port's word offset and bank,
// advances the offset by the burst length when a burst completes, wraps to
// the window start (frame wrap) and applies port restarts (load).
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   min_addr        window start offset
//   max_addr        window end offset (exclusive wrap threshold)
//   len             burst length in words
//   load            port restart request (level)
//   busy            arbiter is in this port's BUSY state
//   done            burst completion for this port (cmd_done while busy)
//   grant           arbiter grants this port this cycle
//   pingpang_en     two-bank double buffering enabled
//   partner_bank    raw bank register of the other port
//   bank            raw bank register of this port
//   addr_next       {bank, offset} this port will present after this edge
// ---------------------------------------------------------------------------
module sdram_addr_gen
    import sdram_rw_arbiter_pkg::*;
#(
    parameter int   ADDR_W   = DEF_ADDR_W,
    parameter int   LEN_W    = DEF_LEN_W,
    parameter bit   IS_READ  = 1'b0,
    parameter logic RST_BANK = BANK_0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-3:0] min_addr,
    input  logic [ADDR_W-3:0] max_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic              load,
    input  logic              busy,
    input  logic              done,
    input  logic              grant,
    input  logic              pingpang_en,
    input  logic              partner_bank,
    output logic              bank,
    output logic [ADDR_W-1:0] addr_next
);

    logic [ADDR_W-3:0] offset_reg, offset_next;
    logic              bank_reg, bank_next;
    logic              init_reg, init_next;
    logic              load_pend_reg, load_pend_next;

    // One extra bit so offset + len can never overflow before the compare.
    logic [ADDR_W-2:0] advanced;
    logic              wrap;

    assign advanced = {1'b0, offset_reg} + {{(ADDR_W-1-LEN_W){1'b0}}, len};
    assign wrap     = (advanced >= {1'b0, max_addr});

    always_comb begin
        offset_next    = offset_reg;
        bank_next      = bank_reg;
        init_next      = init_reg;
        load_pend_next = load_pend_reg;

        if (done) begin
            load_pend_next = 1'b0;
            init_next      = 1'b1;
            // A restart seen during the burst replaces the normal advance.
            if (load_pend_reg || load) begin
                offset_next = min_addr;
                bank_next   = BANK_0;
            end else if (wrap) begin
                offset_next = min_addr;
                if (pingpang_en) begin
                    // Writer flips buffers; reader follows the buffer the
                    // writer is not filling.
                    bank_next = IS_READ ? ~partner_bank : ~bank_reg;
                end
            end else begin
                offset_next = advanced[ADDR_W-3:0];
            end
        end else if (load) begin
            if (busy) begin
                load_pend_next = 1'b1;
            end else begin
                offset_next = min_addr;
                bank_next   = BANK_0;
                init_next   = 1'b1;
            end
        end else if (grant && !init_reg) begin
            // Offsets come out of reset as zero; the first burst of a port
            // that was never restarted starts at the window start.
            offset_next = min_addr;
            init_next   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            offset_reg    <= '0;
            bank_reg      <= RST_BANK;
            init_reg      <= 1'b0;
            load_pend_reg <= 1'b0;
        end else begin
            offset_reg    <= offset_next;
            bank_reg      <= bank_next;
            init_reg      <= init_next;
            load_pend_reg <= load_pend_next;
        end
    end

    // Without double buffering every burst targets bank 0.
    assign addr_next = {1'b0, (pingpang_en ? bank_next : BANK_0), offset_next};
    assign bank      = bank_reg;

endmodule

// File: rtl/sdram_rw_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_rw_arbiter
// Arbitrates write bursts (write FIFO -> SDRAM) and read bursts (SDRAM ->
// read FIFO) towards a single SDRAM command engine, one burst in flight.
// Round-robin between ports when both are pending; each port walks its own
// address window with optional two-bank double buffering.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   init_done                    SDRAM initialised; gates all requests
//   wr_fifo_cnt / rd_fifo_cnt    FIFO fill levels
//   wr_len / rd_len              burst lengths
//   wr_/rd_min_addr, _max_addr   per-port offset window
//   wr_load / rd_load            port restart (level)
//   read_valid                   read port enabled
//   pingpang_en                  double buffering enabled
//   cmd_req/cmd_wr/cmd_addr/cmd_len  burst request to the command engine
//   cmd_ack                      engine accepted the request (pulse)
//   cmd_done                     burst finished (pulse)
// ---------------------------------------------------------------------------
module sdram_rw_arbiter
    import sdram_rw_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_done,
    input  logic [LEN_W-1:0]  wr_fifo_cnt,
    input  logic [LEN_W-1:0]  rd_fifo_cnt,
    input  logic [LEN_W-1:0]  wr_len,
    input  logic [LEN_W-1:0]  rd_len,
    input  logic [ADDR_W-3:0] wr_min_addr,
    input  logic [ADDR_W-3:0] wr_max_addr,
    input  logic [ADDR_W-3:0] rd_min_addr,
    input  logic [ADDR_W-3:0] rd_max_addr,
    input  logic              wr_load,
    input  logic              rd_load,
    input  logic              read_valid,
    input  logic              pingpang_en,
    output logic              cmd_req,
    output logic              cmd_wr,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [LEN_W-1:0]  cmd_len,
    input  logic              cmd_ack,
    input  logic              cmd_done
);

    arb_state_t state_reg, state_next;
    logic       started_reg;
    logic       last_wr_reg;
    logic       wr_pend, rd_pend;
    logic       wr_grant, rd_grant;

    // Per-port views, indexed by PORT_WR / PORT_RD.
    logic [ADDR_W-3:0] min_vec       [2];
    logic [ADDR_W-3:0] max_vec       [2];
    logic [LEN_W-1:0]  len_vec       [2];
    logic [ADDR_W-1:0] addr_next_vec [2];
    logic [1:0]        load_vec, busy_vec, done_vec, grant_vec, bank_vec;

    assign min_vec[PORT_WR] = wr_min_addr;
    assign min_vec[PORT_RD] = rd_min_addr;
    assign max_vec[PORT_WR] = wr_max_addr;
    assign max_vec[PORT_RD] = rd_max_addr;
    assign len_vec[PORT_WR] = wr_len;
    assign len_vec[PORT_RD] = rd_len;

    assign load_vec[PORT_WR]  = wr_load;
    assign load_vec[PORT_RD]  = rd_load;
    assign busy_vec[PORT_WR]  = (state_reg == ST_WR_BUSY);
    assign busy_vec[PORT_RD]  = (state_reg == ST_RD_BUSY);
    assign done_vec           = {2{cmd_done}} & busy_vec;
    assign grant_vec[PORT_WR] = wr_grant;
    assign grant_vec[PORT_RD] = rd_grant;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            sdram_addr_gen #(
                .ADDR_W   (ADDR_W),
                .LEN_W    (LEN_W),
                .IS_READ  (gi == PORT_RD),
                .RST_BANK ((gi == PORT_RD) ? BANK_1 : BANK_0)
            ) u_addr_gen (
                .clk          (clk),
                .rst          (rst),
                .min_addr     (min_vec[gi]),
                .max_addr     (max_vec[gi]),
                .len          (len_vec[gi]),
                .load         (load_vec[gi]),
                .busy         (busy_vec[gi]),
                .done         (done_vec[gi]),
                .grant        (grant_vec[gi]),
                .pingpang_en  (pingpang_en),
                .partner_bank ((gi == PORT_WR) ? bank_vec[PORT_RD] : bank_vec[PORT_WR]),
                .bank         (bank_vec[gi]),
                .addr_next    (addr_next_vec[gi])
            );
        end
    endgenerate

    // A port being restarted is not pending, so a burst never starts from a
    // stale offset.
    assign wr_pend = init_done && (wr_fifo_cnt >= wr_len) && !wr_load;
    assign rd_pend = init_done && read_valid && (rd_fifo_cnt < rd_len) && !rd_load;

    always_comb begin
        state_next = state_reg;
        wr_grant   = 1'b0;
        rd_grant   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // started_reg keeps the first cycle after reset grant-free.
                if (started_reg) begin
                    if (wr_pend && (!rd_pend || (last_wr_reg == GRANT_RD))) begin
                        wr_grant   = 1'b1;
                        state_next = ST_WR_REQ;
                    end else if (rd_pend) begin
                        rd_grant   = 1'b1;
                        state_next = ST_RD_REQ;
                    end
                end
            end
            ST_WR_REQ:  if (cmd_ack)  state_next = ST_WR_BUSY;
            ST_WR_BUSY: if (cmd_done) state_next = ST_IDLE;
            ST_RD_REQ:  if (cmd_ack)  state_next = ST_RD_BUSY;
            ST_RD_BUSY: if (cmd_done) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Command outputs are registered from the next state, so cmd_req rises
    // one cycle after the grant and drops the cycle after cmd_ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            started_reg <= 1'b0;
            last_wr_reg <= GRANT_RD;
            cmd_req     <= 1'b0;
            cmd_wr      <= 1'b0;
            cmd_addr    <= '0;
            cmd_len     <= '0;
        end else begin
            started_reg <= 1'b1;
            cmd_req     <= is_req_state(state_next);
            if (wr_grant) begin
                cmd_wr      <= 1'b1;
                cmd_len     <= wr_len;
                cmd_addr    <= addr_next_vec[PORT_WR];
                last_wr_reg <= GRANT_WR;
            end else if (rd_grant) begin
                cmd_wr      <= 1'b0;
                cmd_len     <= rd_len;
                cmd_addr    <= addr_next_vec[PORT_RD];
                last_wr_reg <= GRANT_RD;
            end else if ((state_reg == ST_WR_REQ) && (state_next == ST_WR_REQ)) begin
                // Track a restart while the request is still waiting.
                cmd_addr <= addr_next_vec[PORT_WR];
            end else if ((state_reg == ST_RD_REQ) && (state_next == ST_RD_REQ)) begin
                cmd_addr <= addr_next_vec[PORT_RD];
            end
        end
    end

endmodule

// File: tb/tb_sdram_rw_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sdram_rw_arbiter
// Randomised bench: the stimulus side plans bursts with a behavioural model
// of the port windows and arbitration, queues the expected commands, and
// plays the SDRAM command engine. An independent monitor compares every
// accepted command (cmd_req && cmd_ack) against the queue.
// ---------------------------------------------------------------------------
module tb_sdram_rw_arbiter;

    localparam int ADDR_W = 24;
    localparam int LEN_W  = 10;
    localparam int OFF_W  = ADDR_W - 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              init_done = 1'b0;
    logic [LEN_W-1:0]  wr_fifo_cnt = '0, rd_fifo_cnt = '0, wr_len = '0, rd_len = '0;
    logic [OFF_W-1:0]  wr_min_addr = '0, wr_max_addr = '0, rd_min_addr = '0, rd_max_addr = '0;
    logic              wr_load = 1'b0, rd_load = 1'b0, read_valid = 1'b0, pingpang_en = 1'b0;
    logic              cmd_req, cmd_wr;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              cmd_ack = 1'b0, cmd_done = 1'b0;

    always #5 clk = ~clk;

    sdram_rw_arbiter #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .init_done(init_done),
        .wr_fifo_cnt(wr_fifo_cnt), .rd_fifo_cnt(rd_fifo_cnt),
        .wr_len(wr_len), .rd_len(rd_len),
        .wr_min_addr(wr_min_addr), .wr_max_addr(wr_max_addr),
        .rd_min_addr(rd_min_addr), .rd_max_addr(rd_max_addr),
        .wr_load(wr_load), .rd_load(rd_load), .read_valid(read_valid),
        .pingpang_en(pingpang_en),
        .cmd_req(cmd_req), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .cmd_ack(cmd_ack), .cmd_done(cmd_done)
    );

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
    } exp_t;

    exp_t exp_q[$];
    int   flag_q[$];   // 0 none, 1 restart while requesting, 2 restart while busy
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: index 0 = write port, 1 = read port.
    int m_off[2], m_bank[2], m_init[2], m_last_wr;
    int c_min[2], c_max[2], c_len[2];
    int c_pp;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endfunction

    // Monitor: every accepted command is matched against the scoreboard.
    always @(negedge clk) begin
        if (!rst && cmd_req && cmd_ack) begin
            exp_t e;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_cmd: got wr=%0d addr=0x%06h len=%0d, expected none",
                         cmd_wr, cmd_addr, cmd_len);
            end else begin
                e = exp_q.pop_front();
                if ({cmd_wr, cmd_addr, cmd_len} !== e) begin
                    miscompares++;
                    $display("FAIL cmd: got wr=%0d addr=0x%06h len=%0d, expected wr=%0d addr=0x%06h len=%0d",
                             cmd_wr, cmd_addr, cmd_len, e.wr, e.addr, e.len);
                end else begin
                    $display("burst ok: wr=%0d addr=0x%06h len=%0d", cmd_wr, cmd_addr, cmd_len);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_off[0] = 0; m_off[1] = 0;
        m_bank[0] = 0; m_bank[1] = 1;
        m_init[0] = 0; m_init[1] = 0;
        m_last_wr = 0;
    endtask

    task automatic apply_cfg();
        wr_len      = LEN_W'(c_len[0]);
        rd_len      = LEN_W'(c_len[1]);
        wr_min_addr = OFF_W'(c_min[0]);
        wr_max_addr = OFF_W'(c_max[0]);
        rd_min_addr = OFF_W'(c_min[1]);
        rd_max_addr = OFF_W'(c_max[1]);
        pingpang_en = c_pp[0];
    endtask

    // Predict one burst of port p and its effect on that port's window.
    function automatic void plan_burst(input int p, input int flag);
        exp_t e;
        if (flag == 1) begin
            m_off[p] = c_min[p];
            m_bank[p] = 0;
        end else if (m_init[p] == 0) begin
            m_off[p] = c_min[p];
        end
        m_init[p] = 1;
        e.wr   = (p == 0);
        e.addr = ADDR_W'(((c_pp != 0 ? m_bank[p] : 0) << OFF_W) + m_off[p]);
        e.len  = LEN_W'(c_len[p]);
        exp_q.push_back(e);
        if (flag == 2) begin
            m_off[p] = c_min[p];
            m_bank[p] = 0;
        end else if (m_off[p] + c_len[p] >= c_max[p]) begin
            m_off[p] = c_min[p];
            if (c_pp != 0) m_bank[p] = (p == 0) ? 1 - m_bank[0] : 1 - m_bank[0];
        end else begin
            m_off[p] = m_off[p] + c_len[p];
        end
        m_last_wr = (p == 0) ? 1 : 0;
    endfunction

    task automatic drive_load(input logic is_wr, input logic v);
        if (is_wr) wr_load = v;
        else       rd_load = v;
    endtask

    task automatic idle_load(input bit do_wr, input bit do_rd);
        wr_load = do_wr;
        rd_load = do_rd;
        step();
        wr_load = 1'b0;
        rd_load = 1'b0;
        for (int p = 0; p < 2; p++) begin
            if ((p == 0 && do_wr) || (p == 1 && do_rd)) begin
                m_off[p] = c_min[p]; m_bank[p] = 0; m_init[p] = 1;
            end
        end
    endtask

    // Plays the command engine for one burst, with spurious pulses mixed in.
    task automatic serve(input bit last);
        int   cnt = 0;
        int   flag;
        logic is_wr;
        while (!cmd_req && cnt < 200) begin
            step();
            cnt++;
        end
        check("req_timeout", 64'(cmd_req), 64'd1);
        if (!cmd_req) return;
        flag  = (flag_q.size() > 0) ? flag_q.pop_front() : 0;
        is_wr = cmd_wr;
        if (flag == 1) begin
            drive_load(is_wr, 1'b1);
            step();
            drive_load(is_wr, 1'b0);
        end
        repeat ($urandom_range(0, 3)) begin
            cmd_done = 1'($urandom_range(0, 1));
            step();
        end
        cmd_done = 1'b0;
        cmd_ack = 1'b1;
        step();
        cmd_ack = 1'b0;
        if (flag == 2) begin
            drive_load(is_wr, 1'b1);
            step();
            drive_load(is_wr, 1'b0);
        end
        repeat ($urandom_range(0, 3)) begin
            cmd_ack = 1'($urandom_range(0, 1));
            step();
        end
        cmd_ack = 1'b0;
        cmd_done = 1'b1;
        if (last) init_done = 1'b0;
        step();
        cmd_done = 1'b0;
    endtask

    task automatic run_segment(input bit wr_en, input bit rd_en, input int n,
                               input int first_flag, input bit rand_flags);
        int flag, p;
        for (int i = 0; i < n; i++) begin
            if (i == 0 && first_flag >= 0) flag = first_flag;
            else if (rand_flags) begin
                case ($urandom_range(0, 5))
                    0:       flag = 1;
                    1:       flag = 2;
                    default: flag = 0;
                endcase
            end else flag = 0;
            if (wr_en && rd_en) p = (m_last_wr != 0) ? 1 : 0;
            else                p = wr_en ? 0 : 1;
            plan_burst(p, flag);
            flag_q.push_back(flag);
        end
        wr_fifo_cnt = wr_en ? LEN_W'($urandom_range(c_len[0], 1023))
                            : LEN_W'($urandom_range(0, c_len[0] - 1));
        if (rd_en) begin
            read_valid  = 1'b1;
            rd_fifo_cnt = LEN_W'($urandom_range(0, c_len[1] - 1));
        end else if ($urandom_range(0, 1) == 0) begin
            read_valid  = 1'b0;
            rd_fifo_cnt = LEN_W'($urandom_range(0, 1023));
        end else begin
            read_valid  = 1'b1;
            rd_fifo_cnt = LEN_W'($urandom_range(c_len[1], 1023));
        end
        init_done = 1'b1;
        step();
        check("grant_latency", 64'(cmd_req), 64'd1);
        for (int i = 0; i < n; i++) serve(i == n - 1);
        init_done = 1'b0;
        step();
        step();
        check("idle_after_seg", 64'(cmd_req), 64'd0);
    endtask

    initial begin
        model_reset();
        repeat (3) step();
        check("rst_outputs", 64'({cmd_req, cmd_wr, cmd_addr, cmd_len}), 64'd0);
        rst = 1'b0;
        repeat (3) step();

        // Both ports pending: write wins first, then strict alternation.
        c_len = '{512, 512}; c_min = '{0, 0}; c_max = '{1024, 1024}; c_pp = 0;
        apply_cfg();
        run_segment(1'b1, 1'b1, 4, 0, 1'b0);

        // Spurious completion/acceptance while idle must change nothing.
        cmd_done = 1'b1; step(); cmd_done = 1'b0;
        cmd_ack  = 1'b1; step(); cmd_ack  = 1'b0;
        step();
        check("spurious_idle", 64'(cmd_req), 64'd0);
        run_segment(1'b1, 1'b0, 1, 0, 1'b0);

        // Double buffering: write wraps into bank 1, read follows into bank 0.
        c_pp = 1;
        apply_cfg();
        idle_load(1'b1, 1'b1);
        run_segment(1'b1, 1'b0, 3, 0, 1'b0);
        run_segment(1'b0, 1'b1, 3, 0, 1'b0);

        // Restart during a write burst: next write goes back to the window start.
        c_pp = 0; c_min[0] = 100; c_max[0] = 2000;
        apply_cfg();
        run_segment(1'b1, 1'b0, 2, 2, 1'b0);

        // No requests at all until the SDRAM reports init done.
        wr_fifo_cnt = 10'd1000; read_valid = 1'b1; rd_fifo_cnt = 10'd0;
        init_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            check("no_req_before_init", 64'(cmd_req), 64'd0);
        end

        // Randomised windows, lengths, port mixes and restarts.
        for (int s = 0; s < 40; s++) begin
            int we, re;
            for (int p = 0; p < 2; p++) begin
                c_len[p] = $urandom_range(1, 600);
                c_min[p] = $urandom_range(0, 3000);
                c_max[p] = c_min[p] + $urandom_range(1, 4000);
            end
            c_pp = $urandom_range(0, 1);
            apply_cfg();
            if ($urandom_range(0, 4) == 0) idle_load($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            we = $urandom_range(0, 2);
            re = (we == 0) ? 1 : $urandom_range(0, 1);
            run_segment(we != 0, re != 0, $urandom_range(1, 5), -1, 1'b1);
        end

        // Reset in the middle of a read burst clears the outputs immediately.
        c_pp = 1; c_len[1] = 300; c_min[1] = 64; c_max[1] = 4000;
        apply_cfg();
        plan_burst(1, 0);
        wr_fifo_cnt = 10'd0; read_valid = 1'b1; rd_fifo_cnt = 10'd0;
        init_done = 1'b1;
        step();
        check("rd_req_latency", 64'(cmd_req), 64'd1);
        cmd_ack = 1'b1; step(); cmd_ack = 1'b0;
        #3 rst = 1'b1;
        #1 check("rst_mid_busy", 64'({cmd_req, cmd_wr, cmd_addr, cmd_len}), 64'd0);

        // After reset release: one grant-free cycle, then the write starts at
        // its window start.
        c_len[0] = 512; c_min[0] = 40; c_max[0] = 1024;
        apply_cfg();
        wr_fifo_cnt = 10'd600; read_valid = 1'b0;
        step();
        rst = 1'b0;
        step();
        check("first_cycle_no_grant", 64'(cmd_req), 64'd0);
        step();
        check("post_rst_req", 64'({cmd_req, cmd_wr, cmd_addr, cmd_len}),
              64'({1'b1, 1'b1, 24'd40, 10'd512}));
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sdram_rw_arbiter.md
SDRAM_RW_ARBITER -- requirements
Module: sdram_rw_arbiter

Interface
REQ-001 Parameter ADDR_W, default 24, SDRAM word address width as {bank[1:0], offset[ADDR_W-3:0]}.
REQ-002 Parameter LEN_W, default 10, width of burst length and FIFO level fields.
REQ-003 clk  in  1  single clock for all logic.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 init_done  in  1  SDRAM init complete; no command is issued while low.
REQ-006 wr_fifo_cnt / rd_fifo_cnt  in  LEN_W  words currently held in the write / read FIFO.
REQ-007 wr_len / rd_len  in  LEN_W  burst lengths, non-zero.
REQ-008 wr_min_addr / wr_max_addr / rd_min_addr / rd_max_addr  in  ADDR_W-2  offset window, min < max.
REQ-009 wr_load / rd_load  in  1  level, port restart.
REQ-010 read_valid  in  1  read port enabled.
REQ-011 pingpang_en  in  1  two-bank double buffering enabled.
REQ-012 cmd_req  out  1  burst request to the SDRAM command engine.
REQ-013 cmd_wr  out  1  1 = write burst, 0 = read burst.
REQ-014 cmd_addr  out  ADDR_W  burst start address.
REQ-015 cmd_len  out  LEN_W  burst length.
REQ-016 cmd_ack  in  1  one-cycle pulse; the engine has accepted the request.
REQ-017 cmd_done  in  1  one-cycle pulse; the last word of the burst has been transferred.

Function
REQ-018 FSM states: IDLE, WR_REQ, WR_BUSY, RD_REQ, RD_BUSY.
REQ-019 Write pending = init_done and wr_fifo_cnt >= wr_len. Read pending = init_done and read_valid and rd_fifo_cnt < rd_len.
REQ-020 In IDLE, if only one request is pending, it is granted.
REQ-021 In IDLE, if both are pending, the port not served last is granted. last_grant resets to read, so write wins first.
REQ-022 Grant -> WR_REQ/RD_REQ one cycle later. In the REQ state, cmd_req = 1 and cmd_wr, cmd_addr, cmd_len are held stable until cmd_ack.
REQ-023 cmd_ack -> BUSY next cycle with cmd_req = 0. cmd_done in BUSY -> IDLE next cycle.
REQ-024 cmd_ack outside a REQ state and cmd_done outside a BUSY state are ignored.
REQ-025 On cmd_done, the port offset advances by len. If offset + len >= max_addr (compare at ADDR_W-1 bits, no overflow), the offset wraps to min_addr and a frame-wrap event occurs.
REQ-026 Write frame-wrap with pingpang_en = 1: wr_bank toggles between 0 and 1.
REQ-027 Read frame-wrap with pingpang_en = 1: rd_bank is set to ~wr_bank.
REQ-028 With pingpang_en = 0, both banks stay 0.
REQ-029 cmd_addr = {bank, offset} of the granted port.
REQ-030 Load in IDLE or a REQ state: the port offset is set to min_addr and its bank to 0 on the next cycle. In a REQ state, cmd_addr is updated and cmd_req stays asserted.
REQ-031 Load during that port's BUSY: the load is latched and applied at cmd_done instead of the advance. No burst is aborted.
REQ-032 While a port's load is asserted, that port is not pending.
REQ-033 Throughput: one burst in flight at most; grant to cmd_req takes 1 cycle.

Reset
REQ-034 rst asserted: state = IDLE, cmd_req = 0, cmd_wr = 0, cmd_addr = 0, cmd_len = 0, offsets = 0, banks wr = 0 / rd = 1, last_grant = read, latched loads cleared.
REQ-035 The first cycle after rst is released performs no grant. Offsets are taken from min_addr via the load rule or on the first grant.

Structure
REQ-036 A shared package holds the state enum, default ADDR_W/LEN_W and bank-index constants.
REQ-037 One sub-module, sdram_addr_gen, is instantiated once per port: offset, bank, wrap and load handling.

Verification
REQ-038 Reset release, wr_fifo_cnt = 512, wr_len = 512, read idle -> cmd_req with cmd_wr = 1, cmd_addr = 0x000000, cmd_len = 512.
REQ-039 Both ports pending continuously -> grants alternate W, R, W, R over 4 bursts, each gated by its ack/done.
REQ-040 wr_min = 0, wr_max = 1024, len = 512 -> offsets 0, 512, then wrap to 0. With pingpang_en = 1, the third write address is 0x400000 (bank 1). The next read after its own wrap uses bank 0.
REQ-041 wr_load asserted mid WR_BUSY -> the burst completes, and the next write address is {0, wr_min_addr}, not the advanced offset.
REQ-042 init_done = 0 with both FIFOs pending -> cmd_req stays 0. Asserting rst mid RD_BUSY -> all outputs return to 0 within the same cycle.
REQ-043 Spurious cmd_done in IDLE and spurious cmd_ack in BUSY -> no state or address change.
